sprite_walker: RTL and testbench

- Parametrised successor to the single-sprite mover: moves a player sprite on the 640x480 playfield from keyboard keycodes, clamped to configurable bounds.
- Adds facing-direction tracking and walk-cycle animation, emitting the sprite-ROM frame index consumed by the colour mapper.
- Outputs a registered hit flag and ROM address, aligned to a synchronous sprite ROM read.
- Sits between the keyboard keycode register, the VGA controller (DrawX/DrawY, frame_clk) and the colour mapper's sprite ROM bank.

---
 rtl/sprite_walker_if.sv | 32 +++
 rtl/sprite_walker.sv | 167 ++++++++++++++++
 tb/tb_sprite_walker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_walker_if.sv
// rtl/sprite_walker_if.sv - signal bundle between the sprite walker and its neighbours
//
// Purpose: groups the frame tick, keyboard, VGA pixel coordinates and the
// sprite outputs into one bundle.
// Ports (as modport views):
//   master : drives frame_clk, keycode, move_en, DrawX, DrawY;
//            observes is_sprite, sprite_address, frame_sel, facing, moving, pos_x, pos_y
//   slave  : the sprite walker side (directions reversed)
interface sprite_walker_if;
   logic        frame_clk;
   logic [7:0]  keycode;
   logic        move_en;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        is_sprite;
   logic [19:0] sprite_address;
   logic [3:0]  frame_sel;
   logic [1:0]  facing;
   logic        moving;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;

   modport master (
      output frame_clk, keycode, move_en, DrawX, DrawY,
      input  is_sprite, sprite_address, frame_sel, facing, moving, pos_x, pos_y
   );

   modport slave (
      input  frame_clk, keycode, move_en, DrawX, DrawY,
      output is_sprite, sprite_address, frame_sel, facing, moving, pos_x, pos_y
   );
endinterface

// File: rtl/sprite_walker.sv
// rtl/sprite_walker.sv - keyboard-driven sprite mover with facing, walk animation and hit test
//
// Purpose: moves a player sprite on the playfield once per frame tick from the
// current keycode, clamped to [X_MIN..X_MAX] x [Y_MIN..Y_MAX], tracks facing
// direction and walk-cycle frame, and produces a registered hit flag and
// sprite ROM address for the pixel presented on the previous Clk.
// Ports:
//   Clk     : system clock
//   Reset_n : asynchronous active-low reset
//   bus     : sprite_walker_if.slave (frame_clk, keycode, move_en, DrawX, DrawY in;
//             is_sprite, sprite_address, frame_sel, facing, moving, pos_x, pos_y out)
module sprite_walker #(
   parameter int unsigned SPR_W       = 38,
   parameter int unsigned SPR_H       = 58,
   parameter int unsigned X_INIT      = 0,
   parameter int unsigned Y_INIT      = 0,
   parameter int unsigned X_MIN       = 0,
   parameter int unsigned X_MAX       = 602,
   parameter int unsigned Y_MIN       = 0,
   parameter int unsigned Y_MAX       = 422,
   parameter int unsigned STEP        = 1,
   parameter int unsigned ANIM_DIV    = 8,
   parameter int unsigned WALK_FRAMES = 2,
   parameter logic [7:0]  KEY_UP      = 8'd26,
   parameter logic [7:0]  KEY_LEFT    = 8'd4,
   parameter logic [7:0]  KEY_DOWN    = 8'd22,
   parameter logic [7:0]  KEY_RIGHT   = 8'd7
) (
   input logic           Clk,
   input logic           Reset_n,
   sprite_walker_if.slave bus
);

   typedef enum logic [1:0] {
      FACE_DOWN  = 2'd0,
      FACE_UP    = 2'd1,
      FACE_LEFT  = 2'd2,
      FACE_RIGHT = 2'd3
   } facing_e;

   localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [3:0]    WALK_LAST = 4'(WALK_FRAMES - 1);
   localparam logic [3:0]    WALK_N    = 4'(WALK_FRAMES);

   // All bound arithmetic is done 11 bits wide so nothing wraps at 0 or 1023.
   localparam logic [10:0] STEP11  = 11'(STEP);
   localparam logic [10:0] X_LO11  = 11'(X_MIN + STEP);
   localparam logic [10:0] Y_LO11  = 11'(Y_MIN + STEP);
   localparam logic [10:0] X_MAX11 = 11'(X_MAX);
   localparam logic [10:0] Y_MAX11 = 11'(Y_MAX);
   localparam logic [10:0] SPR_W11 = 11'(SPR_W);
   localparam logic [10:0] SPR_H11 = 11'(SPR_H);

   logic          frame_clk_d_q;
   logic          tick;
   logic [9:0]    pos_x_q, pos_x_d;
   logic [9:0]    pos_y_q, pos_y_d;
   facing_e       facing_q, facing_d;
   logic          moving_q, moving_d;
   logic [AW-1:0] anim_cnt_q, anim_cnt_d;
   logic [3:0]    walk_idx_q, walk_idx_d;
   logic          is_sprite_q, is_sprite_d;
   logic [19:0]   addr_q, addr_d;

   logic [10:0]   x11, y11, dx11, dy11;
   logic [10:0]   x_dec, x_inc, y_dec, y_inc;
   logic [9:0]    off_x, off_y;

   assign tick = bus.frame_clk & ~frame_clk_d_q;

   assign x11   = {1'b0, pos_x_q};
   assign y11   = {1'b0, pos_y_q};
   assign x_dec = x11 - STEP11;
   assign x_inc = x11 + STEP11;
   assign y_dec = y11 - STEP11;
   assign y_inc = y11 + STEP11;

   // Motion and facing: applied on the same tick the key is seen.
   always_comb begin
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      facing_d = facing_q;
      if (tick && bus.move_en) begin
         if (bus.keycode == KEY_UP) begin
            facing_d = FACE_UP;
            pos_y_d  = (y11 < Y_LO11) ? 10'(Y_MIN) : y_dec[9:0];
         end else if (bus.keycode == KEY_DOWN) begin
            facing_d = FACE_DOWN;
            pos_y_d  = (y_inc > Y_MAX11) ? 10'(Y_MAX) : y_inc[9:0];
         end else if (bus.keycode == KEY_LEFT) begin
            facing_d = FACE_LEFT;
            pos_x_d  = (x11 < X_LO11) ? 10'(X_MIN) : x_dec[9:0];
         end else if (bus.keycode == KEY_RIGHT) begin
            facing_d = FACE_RIGHT;
            pos_x_d  = (x_inc > X_MAX11) ? 10'(X_MAX) : x_inc[9:0];
         end
      end
   end

   // Walk cycle runs only while the position actually changes; a blocked or
   // idle tick drops back to the standing pose.
   always_comb begin
      moving_d   = moving_q;
      anim_cnt_d = anim_cnt_q;
      walk_idx_d = walk_idx_q;
      if (tick) begin
         moving_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
         if (moving_d) begin
            if (anim_cnt_q == ANIM_LAST) begin
               anim_cnt_d = '0;
               walk_idx_d = (walk_idx_q == WALK_LAST) ? 4'd0 : walk_idx_q + 4'd1;
            end else begin
               anim_cnt_d = anim_cnt_q + 1'b1;
            end
         end else begin
            anim_cnt_d = '0;
            walk_idx_d = 4'd0;
         end
      end
   end

   // Hit test against the current (pre-tick) position.
   assign dx11  = {1'b0, bus.DrawX};
   assign dy11  = {1'b0, bus.DrawY};
   assign off_x = bus.DrawX - pos_x_q;
   assign off_y = bus.DrawY - pos_y_q;

   always_comb begin
      is_sprite_d = (dx11 >= x11) && (dx11 < x11 + SPR_W11) &&
                    (dy11 >= y11) && (dy11 < y11 + SPR_H11);
      addr_d      = is_sprite_d ? (20'(off_y) * 20'(SPR_W) + 20'(off_x)) : 20'd0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_clk_d_q <= 1'b0;
         pos_x_q       <= 10'(X_INIT);
         pos_y_q       <= 10'(Y_INIT);
         facing_q      <= FACE_DOWN;
         moving_q      <= 1'b0;
         anim_cnt_q    <= '0;
         walk_idx_q    <= 4'd0;
         is_sprite_q   <= 1'b0;
         addr_q        <= 20'd0;
      end else begin
         frame_clk_d_q <= bus.frame_clk;
         pos_x_q       <= pos_x_d;
         pos_y_q       <= pos_y_d;
         facing_q      <= facing_d;
         moving_q      <= moving_d;
         anim_cnt_q    <= anim_cnt_d;
         walk_idx_q    <= walk_idx_d;
         is_sprite_q   <= is_sprite_d;
         addr_q        <= addr_d;
      end
   end

   assign bus.is_sprite      = is_sprite_q;
   assign bus.sprite_address = addr_q;
   assign bus.frame_sel      = {2'b00, facing_q} * WALK_N + walk_idx_q;
   assign bus.facing         = facing_q;
   assign bus.moving         = moving_q;
   assign bus.pos_x          = pos_x_q;
   assign bus.pos_y          = pos_y_q;

endmodule

// File: tb/tb_sprite_walker.sv
// tb/tb_sprite_walker.sv - self-checking bench for sprite_walker (two parameter sets)
module tb_sprite_walker;

   logic       Clk;
   logic       Reset_n;
   logic       frame_clk;
   logic [7:0] keycode;
   logic       move_en;
   logic [9:0] draw_x, draw_y;

   sprite_walker_if if_a ();
   sprite_walker_if if_b ();

   assign if_a.frame_clk = frame_clk;
   assign if_a.keycode   = keycode;
   assign if_a.move_en   = move_en;
   assign if_a.DrawX     = draw_x;
   assign if_a.DrawY     = draw_y;
   assign if_b.frame_clk = frame_clk;
   assign if_b.keycode   = keycode;
   assign if_b.move_en   = move_en;
   assign if_b.DrawX     = draw_x;
   assign if_b.DrawY     = draw_y;

   sprite_walker #(.ANIM_DIV(2), .WALK_FRAMES(2)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .bus(if_a.slave)
   );

   sprite_walker #(.X_INIT(601), .Y_INIT(1), .STEP(3), .ANIM_DIV(1), .WALK_FRAMES(3)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .bus(if_b.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: plain integer arithmetic; the walk frame is derived
   // from the count of consecutive moving ticks.
   int p_xinit [2] = '{0, 601};
   int p_yinit [2] = '{0, 1};
   int p_step  [2] = '{1, 3};
   int p_div   [2] = '{2, 1};
   int p_wf    [2] = '{2, 3};

   int m_x [2], m_y [2], m_fac [2], m_mov [2], m_run [2], m_hit [2], m_addr [2];
   int m_fprev;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_x[i] = p_xinit[i]; m_y[i] = p_yinit[i];
         m_fac[i] = 0; m_mov[i] = 0; m_run[i] = 0; m_hit[i] = 0; m_addr[i] = 0;
      end
      m_fprev = 0;
   endtask

   task automatic model_step(input int i, input bit tk);
      int nx, ny, dx, dy;
      dx = int'(draw_x);
      dy = int'(draw_y);
      m_hit[i]  = (dx >= m_x[i] && dx < m_x[i] + 38 && dy >= m_y[i] && dy < m_y[i] + 58) ? 1 : 0;
      m_addr[i] = m_hit[i] ? (dy - m_y[i]) * 38 + (dx - m_x[i]) : 0;
      if (tk) begin
         nx = m_x[i];
         ny = m_y[i];
         if (move_en) begin
            case (keycode)
               8'd26: begin m_fac[i] = 1; ny = m_y[i] - p_step[i]; if (ny < 0)   ny = 0;   end
               8'd22: begin m_fac[i] = 0; ny = m_y[i] + p_step[i]; if (ny > 422) ny = 422; end
               8'd4:  begin m_fac[i] = 2; nx = m_x[i] - p_step[i]; if (nx < 0)   nx = 0;   end
               8'd7:  begin m_fac[i] = 3; nx = m_x[i] + p_step[i]; if (nx > 602) nx = 602; end
               default: ;
            endcase
         end
         m_mov[i] = (nx != m_x[i] || ny != m_y[i]) ? 1 : 0;
         m_run[i] = m_mov[i] ? m_run[i] + 1 : 0;
         m_x[i] = nx;
         m_y[i] = ny;
      end
   endtask

   task automatic check_all();
      logic [9:0]  ox, oy;
      logic [1:0]  of;
      logic        om, oh;
      logic [3:0]  ofs;
      logic [19:0] oa;
      string nm;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            nm = "a"; ox = if_a.pos_x; oy = if_a.pos_y; of = if_a.facing; om = if_a.moving;
            ofs = if_a.frame_sel; oh = if_a.is_sprite; oa = if_a.sprite_address;
         end else begin
            nm = "b"; ox = if_b.pos_x; oy = if_b.pos_y; of = if_b.facing; om = if_b.moving;
            ofs = if_b.frame_sel; oh = if_b.is_sprite; oa = if_b.sprite_address;
         end
         chk({nm, ".pos_x"}, 32'(ox), m_x[i]);
         chk({nm, ".pos_y"}, 32'(oy), m_y[i]);
         chk({nm, ".facing"}, 32'(of), m_fac[i]);
         chk({nm, ".moving"}, 32'(om), m_mov[i]);
         chk({nm, ".frame_sel"}, 32'(ofs), m_fac[i] * p_wf[i] + (m_run[i] / p_div[i]) % p_wf[i]);
         chk({nm, ".is_sprite"}, 32'(oh), m_hit[i]);
         chk({nm, ".addr"}, 32'(oa), m_addr[i]);
      end
   endtask

   // One Clk: inputs are changed 1ns after the rising edge, outputs checked then.
   task automatic cycle();
      bit tk;
      @(posedge Clk);
      #1;
      tk = frame_clk && (m_fprev == 0);
      m_fprev = int'(frame_clk);
      model_step(0, tk);
      model_step(1, tk);
      check_all();
   endtask

   task automatic do_tick();
      frame_clk = 1'b1;
      cycle();
      frame_clk = 1'b0;
      cycle();
   endtask

   int exp_fs [5] = '{6, 7, 7, 6, 6};
   int sx, sy, sf, tgt, ks;

   initial begin
      Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'd0; move_en = 1'b1;
      draw_x = 10'd1023; draw_y = 10'd1023;
      model_reset();
      repeat (2) @(posedge Clk);
      #3 Reset_n = 1'b1;
      #1;
      chk("rst.pos_x", 32'(if_a.pos_x), 0);
      chk("rst.pos_y", 32'(if_a.pos_y), 0);
      chk("rst.facing", 32'(if_a.facing), 0);
      chk("rst.frame_sel", 32'(if_a.frame_sel), 0);
      chk("rst.moving", 32'(if_a.moving), 0);
      chk("rst.is_sprite", 32'(if_a.is_sprite), 0);
      chk("rst.addr", 32'(if_a.sprite_address), 0);
      chk("rst.b_pos_x", 32'(if_b.pos_x), 601);
      cycle();

      // Walk right: animation sequence and right-hand clamp.
      keycode = 8'd7;
      for (int t = 0; t < 5; t++) begin
         do_tick();
         chk("walk.frame_sel", 32'(if_a.frame_sel), exp_fs[t]);
         if (t == 0) chk("clamp.b_x_t1", 32'(if_b.pos_x), 602);
         if (t == 1) begin
            chk("clamp.b_x_t2", 32'(if_b.pos_x), 602);
            chk("clamp.b_moving", 32'(if_b.moving), 0);
            chk("clamp.b_facing", 32'(if_b.facing), 3);
         end
      end
      chk("walk.pos_x", 32'(if_a.pos_x), 5);
      chk("walk.facing", 32'(if_a.facing), 3);
      chk("walk.moving", 32'(if_a.moving), 1);
      keycode = 8'd0;
      do_tick();
      chk("idle.moving", 32'(if_a.moving), 0);
      chk("idle.frame_sel", 32'(if_a.frame_sel), 6);

      // Up near the top edge: clamp to 0, no wrap.
      keycode = 8'd26;
      do_tick();
      chk("up.b_pos_y", 32'(if_b.pos_y), 0);
      chk("up.a_pos_y", 32'(if_a.pos_y), 0);
      chk("up.a_facing", 32'(if_a.facing), 1);
      do_tick();
      chk("up.b_pos_y2", 32'(if_b.pos_y), 0);

      // Freeze: keys ignored.
      move_en = 1'b0;
      sx = int'(if_a.pos_x); sy = int'(if_a.pos_y); sf = int'(if_a.facing);
      for (int t = 0; t < 3; t++) begin
         do_tick();
         chk("frz.pos_x", 32'(if_a.pos_x), sx);
         chk("frz.pos_y", 32'(if_a.pos_y), sy);
         chk("frz.facing", 32'(if_a.facing), sf);
         chk("frz.moving", 32'(if_a.moving), 0);
         chk("frz.frame_sel", 32'(if_a.frame_sel), 2);
      end
      move_en = 1'b1;

      // Walk sprite A to (100,50) and probe its edges.
      keycode = 8'd7;
      repeat (95) do_tick();
      keycode = 8'd22;
      repeat (50) do_tick();
      keycode = 8'd0;
      chk("hit.pos_x", 32'(if_a.pos_x), 100);
      chk("hit.pos_y", 32'(if_a.pos_y), 50);
      draw_x = 10'd137; draw_y = 10'd107;
      cycle();
      chk("hit.in", 32'(if_a.is_sprite), 1);
      chk("hit.addr", 32'(if_a.sprite_address), 2203);
      draw_x = 10'd138;
      cycle();
      chk("hit.right", 32'(if_a.is_sprite), 0);
      chk("hit.right_addr", 32'(if_a.sprite_address), 0);
      draw_x = 10'd99;
      cycle();
      chk("hit.left", 32'(if_a.is_sprite), 0);
      chk("hit.left_addr", 32'(if_a.sprite_address), 0);

      // Asynchronous reset mid-walk.
      keycode = 8'd7;
      do_tick();
      do_tick();
      cycle();
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst.pos_x", 32'(if_a.pos_x), 0);
      chk("arst.pos_y", 32'(if_a.pos_y), 0);
      chk("arst.facing", 32'(if_a.facing), 0);
      chk("arst.moving", 32'(if_a.moving), 0);
      chk("arst.b_pos_x", 32'(if_b.pos_x), 601);
      check_all();
      #3 Reset_n = 1'b1;
      do_tick();
      chk("arst.first_x", 32'(if_a.pos_x), 1);
      chk("arst.first_bx", 32'(if_b.pos_x), 602);

      // Randomised run against the model.
      for (int c = 0; c < 3000; c++) begin
         frame_clk = ($urandom % 4 == 0);
         if ($urandom % 8 == 0) begin
            ks = int'($urandom % 6);
            case (ks)
               0: keycode = 8'd26;
               1: keycode = 8'd4;
               2: keycode = 8'd22;
               3: keycode = 8'd7;
               4: keycode = 8'd0;
               default: keycode = 8'($urandom);
            endcase
         end
         move_en = ($urandom % 8 != 0);
         tgt = c % 2;
         sx = m_x[tgt] + int'($urandom_range(0, 44)) - 3;
         sy = m_y[tgt] + int'($urandom_range(0, 64)) - 3;
         if (sx < 0) sx = 0;
         if (sx > 1023) sx = 1023;
         if (sy < 0) sy = 0;
         if (sy > 1023) sy = 1023;
         draw_x = 10'(sx);
         draw_y = 10'(sy);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
